// File: rtl/drp_pkg.sv
// Shared DRP definitions: sequencer state encoding and the PLL DRP register map window.
package drp_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_ON    = 3'd1,
    S_RD        = 3'd2,
    S_RD_WAIT   = 3'd3,
    S_WR        = 3'd4,
    S_WR_WAIT   = 3'd5,
    S_RST_OFF   = 3'd6,
    S_LOCK_WAIT = 3'd7
  } drp_state_t;

  // PLL configuration registers occupy 0x06..0x4F of the DRP space.
  localparam logic [6:0] DRP_ADDR_FIRST        = 7'h06;
  localparam logic [6:0] DRP_ADDR_CLKOUT0_REG1 = 7'h08;
  localparam logic [6:0] DRP_ADDR_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] DRP_ADDR_LAST         = 7'h4F;

  function automatic logic [15:0] rmw_merge(input logic [15:0] rd_val,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd_val & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/drp_rmw_master.sv
// Read-modify-write of one PLL DRP register with the PLL held in reset, then waits for re-lock.
//
// state       | meaning
// IDLE        | waiting for START; request fields latched on accept
// RST_ON      | PLL_RST asserted
// RD          | one-cycle DRP read strobe
// RD_WAIT     | waiting for read DRDY, DO captured
// WR          | one-cycle DRP write strobe with merged data
// WR_WAIT     | waiting for write DRDY
// RST_OFF     | PLL_RST released
// LOCK_WAIT   | waiting for LOCKED
module drp_rmw_master
  import drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        START,
  input  logic [6:0]  ADDR,
  input  logic [15:0] MASK,
  input  logic [15:0] DATA,
  input  logic        LOCKED,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  // DONE/ERROR are registered, so the last wait cycle sits one before the timeout
  // boundary; the ERROR pulse then lands exactly TIMEOUT cycles after the launching cycle.
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 2);

  drp_state_t        state_q, state_d;
  logic [6:0]        addr_q, addr_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    rd_d    = rd_q;
    cnt_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = ADDR;
          mask_d  = MASK;
          data_d  = DATA;
          state_d = S_RST_ON;
        end
      end
      S_RST_ON: state_d = S_RD;
      S_RD:     state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (DRDY) begin
          rd_d    = DO;
          state_d = S_WR;
        end else if (cnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR:     state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (DRDY) begin
          state_d = S_RST_OFF;
        end else if (cnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RST_OFF: state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        if (LOCKED) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DEN     = (state_q == S_RD) || (state_q == S_WR);
  assign DWE     = (state_q == S_WR);
  assign DADDR   = addr_q;
  assign DI      = rmw_merge(rd_q, mask_q, data_q);
  assign PLL_RST = state_q inside {S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT};
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign ERROR   = err_q;

endmodule

// File: tb/tb_drp_rmw_master.sv
// Bench for drp_rmw_master: DRP responder, PLL lock model and a schedule-based reference.
module tb_drp_rmw_master;
  import drp_pkg::*;

  localparam int T_D = 64;
  localparam int T_L = 1024;

  logic        DCLK = 1'b0;
  logic        RST, START, LOCKED;
  logic [6:0]  ADDR, DADDR;
  logic [15:0] MASK, DATA, DI, DO;
  logic        DEN, DWE, DRDY, PLL_RST, BUSY, DONE, ERROR;
  logic        resp_drdy = 1'b0;
  logic        stray_drdy = 1'b0;

  assign DRDY = resp_drdy | stray_drdy;

  drp_rmw_master #(.DRDY_TIMEOUT(T_D), .LOCK_TIMEOUT(T_L)) dut (
    .DCLK(DCLK), .RST(RST), .START(START), .ADDR(ADDR), .MASK(MASK), .DATA(DATA),
    .LOCKED(LOCKED), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO),
    .DRDY(DRDY), .PLL_RST(PLL_RST), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 DCLK = ~DCLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge DCLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  // responder memory (updated from the DUT's writes) and model memory (updated by the model)
  logic [15:0] rmem [128];
  logic [15:0] mmem [128];
  int   resp_lat = 3;        // DRDY this many cycles after DEN; 0 = never answers
  bit   resp_pend = 0;
  int   resp_fire = 0;
  logic [6:0] resp_addr = '0;
  int   lock_d = 0;          // LOCKED rises lock_d cycles after PLL_RST falls (min 1 into LOCK_WAIT)
  int   low_cnt = 0;

  // observations used by the hand-computed checks
  int den_cnt = 0, last_den_cyc = 0, done_cyc = -1, err_cyc = -1, fall_cyc = 0;
  logic [15:0] last_wr_di = '0;
  logic pll_prev = 1'b0;

  always @(posedge DCLK) begin
    #1;
    resp_drdy = 1'b0;
    DO = 16'($urandom);
    if (resp_pend && cyc == resp_fire) begin
      resp_drdy = 1'b1;
      DO = rmem[resp_addr];
      resp_pend = 0;
    end
    if (PLL_RST === 1'b1) low_cnt = 0;
    else if (low_cnt < 1000000) low_cnt++;
    LOCKED = (low_cnt > lock_d);
  end

  // reference model: each accepted request becomes a schedule of absolute cycles
  bit   m_act = 0, m_has_w = 0, m_ok = 0, m_rst_chk = 0;
  int   m_s, m_r, m_w, m_o, m_e;
  logic [6:0]  m_addr;
  logic [15:0] m_di;

  always @(negedge DCLK) begin
    int c, k;
    bit e_den, e_dwe, e_busy, e_pll, e_done, e_err;
    c = cyc;
    {e_den, e_dwe, e_busy, e_pll, e_done, e_err} = '0;
    if (m_act) begin
      if (c < m_e) begin
        e_busy = 1;
        e_pll  = m_has_w ? (c < m_o) : 1'b1;
        e_den  = (c == m_r) || (m_has_w && c == m_w);
        e_dwe  = m_has_w && (c == m_w);
        if (m_has_w && c == m_w) mmem[m_addr] = m_di;
      end else begin
        e_done = m_ok;
        e_err  = !m_ok;
        m_act  = 0;
      end
    end
    chk("den", DEN, e_den);
    chk("dwe", DWE, e_dwe);
    chk("busy", BUSY, e_busy);
    chk("pll_rst", PLL_RST, e_pll);
    chk("done", DONE, e_done);
    chk("error", ERROR, e_err);
    if (e_den) chk("daddr", DADDR, m_addr);
    if (e_dwe) chk("di", DI, m_di);
    if (m_rst_chk) begin
      chk("rst_daddr", DADDR, 0);
      chk("rst_di", DI, 0);
      m_rst_chk = 0;
    end

    if (DEN === 1'b1) begin
      den_cnt++;
      last_den_cyc = c;
      if (resp_lat > 0) begin
        resp_pend = 1;
        resp_fire = c + resp_lat;
        resp_addr = DADDR;
      end
      if (DWE === 1'b1) begin
        rmem[DADDR] = DI;
        last_wr_di = DI;
      end
    end
    if (DONE === 1'b1) done_cyc = c;
    if (ERROR === 1'b1) err_cyc = c;
    if (pll_prev === 1'b1 && PLL_RST === 1'b0) fall_cyc = c;
    pll_prev = PLL_RST;

    if (RST === 1'b1) begin
      m_act = 0;
      m_rst_chk = 1;
    end else if (START === 1'b1 && !m_act) begin
      m_act  = 1;
      m_s    = c;
      m_addr = ADDR;
      m_di   = (mmem[ADDR] & MASK) | (DATA & ~MASK);
      m_r    = c + 2;
      if (resp_lat < 1 || resp_lat > T_D - 1) begin
        m_has_w = 0;
        m_ok    = 0;
        m_e     = m_r + T_D;
      end else begin
        m_has_w = 1;
        m_w     = m_r + resp_lat + 1;
        m_o     = m_w + resp_lat + 1;
        k       = m_o + ((lock_d > 1) ? lock_d : 1);
        m_ok    = (k <= m_o + T_L - 1);
        m_e     = m_ok ? k + 1 : m_o + T_L;
      end
    end
  end

  task automatic run_tx(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input bit spam, output int s);
    int n;
    @(posedge DCLK); #1;
    ADDR = a; MASK = m; DATA = d; START = 1'b1;
    s = cyc;
    @(posedge DCLK); #1;
    START = 1'b0;
    if (spam) begin
      repeat (4) begin
        START = 1'($urandom_range(0, 1));
        ADDR  = 7'($urandom);
        MASK  = 16'($urandom);
        DATA  = 16'($urandom);
        @(posedge DCLK); #1;
      end
      START = 1'b0;
    end
    n = 0;
    do begin
      @(negedge DCLK);
      n++;
    end while (!(DONE === 1'b1 || ERROR === 1'b1) && n < 3000);
    chk("tx_end_seen", 32'(n < 3000), 1);
    #1;
  endtask

  initial begin
    int s;
    RST = 1'b1; START = 1'b0; ADDR = '0; MASK = '0; DATA = '0; LOCKED = 1'b0; DO = '0;
    for (int i = 0; i < 128; i++) begin
      rmem[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
      mmem[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
    end
    rmem[8] = 16'h1234;
    mmem[8] = 16'h1234;
    repeat (3) @(posedge DCLK);
    #1 RST = 1'b0;
    @(negedge DCLK);
    chk("reset_busy", BUSY, 0);

    // basic RMW on 0x08 and readback
    resp_lat = 3; lock_d = 0; den_cnt = 0;
    run_tx(DRP_ADDR_CLKOUT0_REG1, 16'hFF00, 16'h0056, 0, s);
    chk("rmw_di", last_wr_di, 16'h1256);
    chk("rmw_done_lat", done_cyc - s, 12);
    chk("rmw_dens", den_cnt, 2);
    chk("rmw_mem", rmem[8], 16'h1256);
    run_tx(DRP_ADDR_CLKOUT0_REG1, 16'hFFFF, 16'h0000, 0, s);
    chk("readback", last_wr_di, 16'h1256);

    // fastest handshake: DRDY the cycle after each DEN, lock already present
    resp_lat = 1; lock_d = 0;
    run_tx(DRP_ADDR_CLKFBOUT_REG1, 16'h00FF, 16'hAB00, 0, s);
    chk("min_len", done_cyc - s, 8);

    // responder never answers
    resp_lat = 0; den_cnt = 0;
    run_tx(7'h10, 16'h0F0F, 16'h1111, 0, s);
    chk("drdy_to_lat", err_cyc - last_den_cyc, 64);
    chk("drdy_to_pll", PLL_RST, 0);
    repeat (5) @(negedge DCLK);
    chk("drdy_to_dens", den_cnt, 1);

    // PLL never locks
    resp_lat = 2; lock_d = 5000;
    run_tx(7'h20, 16'h0000, 16'hBEEF, 0, s);
    chk("lock_to_lat", err_cyc - fall_cyc, 1024);
    chk("lock_to_busy", BUSY, 0);
    @(negedge DCLK);
    chk("lock_to_busy_next", BUSY, 0);
    lock_d = 0;

    // START pulsed while busy
    resp_lat = 2; den_cnt = 0;
    run_tx(7'h30, 16'hF000, 16'h0ABC, 1, s);
    chk("spam_dens", den_cnt, 2);

    // reset while in WR_WAIT
    resp_lat = 10; done_cyc = -1; err_cyc = -1;
    @(posedge DCLK); #1;
    ADDR = 7'h40; MASK = 16'h1234; DATA = 16'h4321; START = 1'b1;
    @(posedge DCLK); #1;
    START = 1'b0;
    repeat (15) @(posedge DCLK);
    #1;
    chk("pre_rst_pll", PLL_RST, 1);
    RST = 1'b1;
    @(posedge DCLK); #1;
    RST = 1'b0;
    @(negedge DCLK);
    chk("rst_outputs", {DEN, DWE, PLL_RST, BUSY, DONE, ERROR, DADDR, DI}, 0);
    repeat (30) @(negedge DCLK);
    chk("rst_no_done", done_cyc, -1);
    chk("rst_no_error", err_cyc, -1);

    // randomized requests
    for (int i = 0; i < 40; i++) begin
      resp_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
      lock_d   = ($urandom_range(0, 14) == 0) ? 5000 : int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 5)) begin
        @(posedge DCLK); #1;
        stray_drdy = 1'($urandom_range(0, 1));
      end
      stray_drdy = 1'b0;
      run_tx(7'($urandom_range(DRP_ADDR_FIRST, DRP_ADDR_LAST)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), s);
    end

    repeat (3) @(negedge DCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: run did not complete, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/drp_rmw_master.md
DRP_RMW_MASTER -- requirements
Module: drp_rmw_master

Interface
REQ-001 Parameter DRDY_TIMEOUT, default 64, SHALL set the maximum DCLK cycles waited for DRDY after each DEN pulse.
REQ-002 Parameter LOCK_TIMEOUT, default 1024, SHALL set the maximum DCLK cycles waited for LOCKED after PLL reset release.
REQ-003 DCLK  input  1  SHALL be the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 START  input  1  SHALL request one read-modify-write; it SHALL be sampled only in IDLE.
REQ-006 ADDR  input  7  SHALL give the target DRP register address.
REQ-007 MASK  input  16  SHALL mark, with 1-bits, the bits to keep from the read value.
REQ-008 DATA  input  16  SHALL give the new values for bits whose MASK bit is 0.
REQ-009 LOCKED  input  1  SHALL be the PLL lock indication.
REQ-010 DADDR  output  7  SHALL be the DRP address.
REQ-011 DEN  output  1  SHALL be the DRP enable strobe.
REQ-012 DWE  output  1  SHALL be the DRP write enable.
REQ-013 DI  output  16  SHALL be the DRP write data.
REQ-014 DO  input  16  SHALL be the DRP read data.
REQ-015 DRDY  input  1  SHALL be the DRP ready pulse.
REQ-016 PLL_RST  output  1  SHALL hold the PLL in reset during reconfiguration.
REQ-017 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-018 DONE  output  1  SHALL pulse high for one cycle on successful completion.
REQ-019 ERROR  output  1  SHALL pulse high for one cycle on any timeout.

Function
REQ-020 States SHALL be IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, LOCK_WAIT.
REQ-021 IDLE with START=1: ADDR, MASK and DATA SHALL be latched; next state RST_ON; START while BUSY SHALL be ignored.
REQ-022 RST_ON: PLL_RST SHALL go high and stay high through WR_WAIT; next state RD.
REQ-023 RD: DEN=1, DWE=0, DADDR=latched ADDR for exactly one cycle; next state RD_WAIT.
REQ-024 RD_WAIT: when DRDY=1, DO SHALL be captured and the next state SHALL be WR.
REQ-025 WR: DEN=1, DWE=1 for exactly one cycle; DI SHALL equal (captured DO AND MASK) OR (DATA AND NOT MASK); next state WR_WAIT.
REQ-026 WR_WAIT: on DRDY=1 the next state SHALL be RST_OFF.
REQ-027 RST_OFF: PLL_RST SHALL go low; next state LOCK_WAIT.
REQ-028 LOCK_WAIT: when LOCKED=1, DONE SHALL pulse and the next state SHALL be IDLE.
REQ-029 The wait counter SHALL clear on entry to each wait state and increment each cycle in that state.
REQ-030 DRDY_TIMEOUT expiry in RD_WAIT or WR_WAIT SHALL pulse ERROR, drop PLL_RST and return to IDLE without any further DEN.
REQ-031 LOCK_TIMEOUT expiry SHALL pulse ERROR and return to IDLE.
REQ-032 DEN SHALL never be high on two consecutive cycles.
REQ-033 A DRDY arriving outside RD_WAIT or WR_WAIT SHALL be ignored.
REQ-034 A DRDY arriving in the cycle after DEN SHALL be accepted, giving a minimum transaction length of 8 cycles.
REQ-035 DONE and ERROR SHALL never be high together.

Reset
REQ-036 RST=1 SHALL force IDLE and set DEN, DWE, PLL_RST, BUSY, DONE and ERROR to 0, DADDR to 0, DI to 0, and all latches and counters to 0, on the next DCLK edge.
REQ-037 RST asserted mid-transaction SHALL abort the transaction with no DONE or ERROR pulse, and PLL_RST SHALL fall at that edge.

Structure
REQ-038 State encoding and DRP address constants (0x06-0x4F map) SHALL live in shared package drp_pkg.
REQ-039 The block SHALL be one FSM module with one wait counter sized for max(DRDY_TIMEOUT, LOCK_TIMEOUT); no sub-module.

Verification
REQ-040 Bench SHALL use a DRP responder model with DRDY 3 cycles after DEN and register 0x08 = 0x1234; START with ADDR=0x08, MASK=0xFF00, DATA=0x0056 -> write DI=0x1256, then DONE pulse, and readback 0x1256.
REQ-041 Bench SHALL run a responder that never asserts DRDY -> ERROR exactly 64 cycles after the RD strobe, PLL_RST=0, exactly one DEN issued.
REQ-042 Bench SHALL hold LOCKED=0 -> ERROR 1024 cycles after RST_OFF, BUSY=0 the next cycle.
REQ-043 Bench SHALL assert RST during WR_WAIT -> all outputs 0 the next cycle, no DONE, no ERROR.
REQ-044 Bench SHALL pulse START again while BUSY -> ignored, exactly two DEN pulses per accepted request.
REQ-045 Bench SHALL drive DRDY in the cycle after DEN -> accepted, DONE 8 cycles after START when LOCKED is already high.
